falco_lsu_requester: RTL and testbench
======================================

Name: falco_lsu_requester

Overview:
- Initiator side of the Falco core load/store memory interface. It issues store_req, load_ck_hit_req and load_data_req, and consumes store_resp, load_hit_resp and load_data_resp.
- Sits between the core's memory-op issue logic and the memory (the behavioural memory model in simulation, the cache in silicon).
- Buffers core ops in a small FIFO and sequences each one through a handshake FSM with retry and timeout.
- Returns exactly one tagged completion per accepted op.

Parameters:
- FIFO_DEPTH, 4, op queue depth (power of 2, ≥2)
- TAG_W, 4, op tag width
- MAX_RETRY, 3, load hit-check misses tolerated before an error completion
- TIMEOUT, 16, wait-state cycles before an error completion

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  core presents an op
- op_ready  out  1  FIFO can accept an op
- op_is_store  in  1  1=store, 0=load
- op_addr  in  `SIZE_OF_THE_BUS  byte address
- op_wdata  in  `SIZE_OF_THE_BUS  store data
- op_tag  in  TAG_W  op identifier
- store_req  out  core_store_req_t  store request (store_req, store_addr, store_data)
- load_ck_hit_req  out  core_load_ck_hit_req_t  hit-check request (load_req, load_addr)
- load_data_req  out  core_load_data_req_t  data request (load_req, load_addr)
- store_resp  in  core_store_resp_t  store_finished, store_miss
- load_hit_resp  in  core_load_hit_resp_t  load_hit, load_miss
- load_data_resp  in  core_load_data_resp_t  load_data, load_finished, load_miss
- done_valid  out  1  completion pulse, 1 cycle
- done_tag  out  TAG_W  tag of completed op
- done_rdata  out  `SIZE_OF_THE_BUS  load data; 0 for stores and errors
- done_err  out  2  0=ok, 1=misaligned, 2=retry exhausted, 3=timeout

Behaviour:
- Reset: all request strobes 0, addr/data fields 0, done_valid 0, done_tag 0, done_rdata 0, done_err 0. FIFO empty, op_ready 1, FSM IDLE, counters 0.
- A reset that arrives mid-operation abandons the in-flight op and all queued ops. No completion is produced for any of them.
- Enqueue: an op is accepted when op_valid && op_ready. op_ready = !full.
  - Simultaneous enqueue and dequeue while full is not allowed, because op_ready is already 0.
  - Pointers wrap modulo FIFO_DEPTH. A full/empty extra bit distinguishes the full and empty cases.
- FSM states: IDLE, CHECK_ALIGN, ST_REQ, ST_WAIT, HIT_REQ, HIT_WAIT, LD_REQ, LD_WAIT, DONE.
- IDLE: if the FIFO is not empty, pop the head into the op register and go to CHECK_ALIGN. The pop is registered.
- CHECK_ALIGN: if addr[1:0]!=0, set err=1 and go to DONE; no request is issued. Otherwise go to ST_REQ for a store or HIT_REQ for a load.
- *_REQ states: drive the matching request strobe for exactly 1 cycle, with addr/data held from the op register. Then go to the matching *_WAIT state.
  - Strobes are 0 in every other state. At most one strobe is high in any cycle.
- Wait states: response flags are sampled only in *_WAIT states, starting the cycle after the strobe. Responses may be sticky (level), so flags outside wait states are ignored.
- ST_WAIT:
  - store_finished && !store_miss: go to DONE, err=0.
  - store_miss: go back to ST_REQ. This retry is not counted against MAX_RETRY.
- HIT_WAIT:
  - load_hit: go to LD_REQ.
  - load_miss: increment retry_cnt. If retry_cnt==MAX_RETRY, set err=2 and go to DONE; otherwise go back to HIT_REQ.
  - If load_hit and load_miss are both set, load_hit wins.
- LD_WAIT:
  - load_finished && !load_miss: capture load_data into done_rdata and go to DONE.
  - load_miss: go back to LD_REQ.
- Timeout: the wait counter resets on entry to each *_WAIT state. When it reaches TIMEOUT-1 without a qualifying response, set err=3 and go to DONE.
- DONE: done_valid=1 for 1 cycle, carrying the tag, rdata and err of the op. retry_cnt clears. Go to IDLE.
- Latency: with an immediately-responding memory, a store completes in 4 cycles from pop and a load in 6.
- Ops complete strictly in FIFO order, with one op in flight at a time.

Decomposition:
- Falco_pkg already holds core_store_req_t, core_load_data_req_t, core_load_ck_hit_req_t and the three response structs. Add to it:
  - the lsu_state_e enum
  - the lsu_err_e enum (LSU_OK, LSU_MISALIGN, LSU_RETRY, LSU_TIMEOUT)
  - the lsu_op_t struct (is_store, addr, wdata, tag)
- Sub-module falco_lsu_op_fifo: a parameterised synchronous FIFO of lsu_op_t, with push/pop/full/empty and the same clk/rst.

Test Plan:
- Store addr 0x100, data 0xDEADBEEF, tag 2, memory finishes in 1 cycle -> single store_req pulse with addr 0x100, data 0xDEADBEEF; done_valid with tag 2, err 0, rdata 0.
- Load addr 0x100 after the prior store, hit and finish immediately -> hit strobe then data strobe; done_rdata 0xDEADBEEF, err 0, 6 cycles from pop.
- Load addr 0x203 -> no strobes issued; done_err 1 two cycles after pop.
- Load with load_hit_resp.load_miss forced high -> 3 hit strobes, then done_err 2, no data strobe.
- Store with no store_finished ever -> done_err 3 exactly TIMEOUT cycles after entering ST_WAIT.
- Push 5 ops back-to-back with the memory stalled -> op_ready drops after 4 are queued (the first pops at cycle +1, so the 5th is accepted later). Completions come out in tag order 0..4. Assert rst mid-LD_WAIT -> all outputs return to reset values, no done_valid.

Source files
------------

// File: rtl/falco_pkg.sv
// Shared Falco core memory-interface types plus the load/store requester's state,
// error and op types.
`ifndef SIZE_OF_THE_BUS
`define SIZE_OF_THE_BUS 32
`endif

package falco_pkg;

  localparam int unsigned BusW       = `SIZE_OF_THE_BUS;
  // Widest op tag the queued op record can carry; the requester's TAG_W must not exceed it.
  localparam int unsigned LsuTagMaxW = 8;

  typedef struct packed {
    logic            store_req;
    logic [BusW-1:0] store_addr;
    logic [BusW-1:0] store_data;
  } core_store_req_t;

  typedef struct packed {
    logic            load_req;
    logic [BusW-1:0] load_addr;
  } core_load_ck_hit_req_t;

  typedef struct packed {
    logic            load_req;
    logic [BusW-1:0] load_addr;
  } core_load_data_req_t;

  typedef struct packed {
    logic store_finished;
    logic store_miss;
  } core_store_resp_t;

  typedef struct packed {
    logic load_hit;
    logic load_miss;
  } core_load_hit_resp_t;

  typedef struct packed {
    logic [BusW-1:0] load_data;
    logic            load_finished;
    logic            load_miss;
  } core_load_data_resp_t;

  typedef enum logic [3:0] {
    StIdle,
    StCheckAlign,
    StStReq,
    StStWait,
    StHitReq,
    StHitWait,
    StLdReq,
    StLdWait,
    StDone
  } lsu_state_e;

  typedef enum logic [1:0] {
    LSU_OK       = 2'd0,
    LSU_MISALIGN = 2'd1,
    LSU_RETRY    = 2'd2,
    LSU_TIMEOUT  = 2'd3
  } lsu_err_e;

  typedef struct packed {
    logic                  is_store;
    logic [BusW-1:0]       addr;
    logic [BusW-1:0]       wdata;
    logic [LsuTagMaxW-1:0] tag;
  } lsu_op_t;

endpackage

// File: rtl/falco_lsu_op_fifo.sv
// Synchronous FIFO of pending load/store ops; an extra pointer bit separates full from empty.
module falco_lsu_op_fifo
  import falco_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  lsu_op_t wdata_i,
  input  logic    pop_i,
  output lsu_op_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  logic [PtrW:0] wptr_q, wptr_d;
  logic [PtrW:0] rptr_q, rptr_d;
  lsu_op_t       mem_q [Depth];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i && !full_o) wptr_d = wptr_q + PtrOne;
    if (pop_i && !empty_o) rptr_d = rptr_q + PtrOne;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

endmodule

// File: rtl/falco_lsu_requester.sv
// Load/store requester: queues core memory ops and walks each one through a
// request/response handshake with retry and timeout, emitting one tagged completion per op.
`ifndef SIZE_OF_THE_BUS
`define SIZE_OF_THE_BUS 32
`endif

module falco_lsu_requester
  import falco_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic                        op_is_store,
  input  logic [`SIZE_OF_THE_BUS-1:0] op_addr,
  input  logic [`SIZE_OF_THE_BUS-1:0] op_wdata,
  input  logic [TAG_W-1:0]            op_tag,
  output core_store_req_t             store_req,
  output core_load_ck_hit_req_t       load_ck_hit_req,
  output core_load_data_req_t         load_data_req,
  input  core_store_resp_t            store_resp,
  input  core_load_hit_resp_t         load_hit_resp,
  input  core_load_data_resp_t        load_data_resp,
  output logic                        done_valid,
  output logic [TAG_W-1:0]            done_tag,
  output logic [`SIZE_OF_THE_BUS-1:0] done_rdata,
  output logic [1:0]                  done_err
);

  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  localparam int unsigned WaitW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [RetryW-1:0] RetryOne  = {{(RetryW-1){1'b0}}, 1'b1};
  localparam logic [RetryW-1:0] RetryLast = RetryW'(MAX_RETRY - 1);
  localparam logic [WaitW-1:0]  WaitOne   = {{(WaitW-1){1'b0}}, 1'b1};
  localparam logic [WaitW-1:0]  WaitLast  = WaitW'(TIMEOUT - 1);

  lsu_state_e              state_q, state_d;
  lsu_op_t                 op_q, op_d;
  lsu_err_e                err_q, err_d;
  logic [BusW-1:0]         rdata_q, rdata_d;
  logic [RetryW-1:0]       retry_cnt_q, retry_cnt_d;
  logic [WaitW-1:0]        wait_cnt_q, wait_cnt_d;

  logic    fifo_full, fifo_empty, fifo_pop, fifo_push;
  lsu_op_t fifo_wdata, fifo_rdata;

  assign op_ready   = !fifo_full;
  assign fifo_push  = op_valid && op_ready;
  assign fifo_wdata = '{is_store: op_is_store, addr: op_addr, wdata: op_wdata,
                        tag: LsuTagMaxW'(op_tag)};

  falco_lsu_op_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_op_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    err_d           = err_q;
    rdata_d         = rdata_q;
    retry_cnt_d     = retry_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    fifo_pop        = 1'b0;
    store_req       = '0;
    load_ck_hit_req = '0;
    load_data_req   = '0;
    done_valid      = 1'b0;
    done_tag        = '0;
    done_rdata      = '0;
    done_err        = LSU_OK;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = fifo_rdata;
          err_d    = LSU_OK;
          rdata_d  = '0;
          state_d  = StCheckAlign;
        end
      end
      StCheckAlign: begin
        if (op_q.addr[1:0] != 2'b00) begin
          err_d   = LSU_MISALIGN;
          state_d = StDone;
        end else begin
          state_d = op_q.is_store ? StStReq : StHitReq;
        end
      end
      StStReq: begin
        store_req  = '{store_req: 1'b1, store_addr: op_q.addr, store_data: op_q.wdata};
        wait_cnt_d = '0;
        state_d    = StStWait;
      end
      StStWait: begin
        // Store misses re-issue without consuming the hit-check retry budget.
        if (store_resp.store_finished && !store_resp.store_miss) begin
          state_d = StDone;
        end else if (store_resp.store_miss) begin
          state_d = StStReq;
        end else if (wait_cnt_q == WaitLast) begin
          err_d   = LSU_TIMEOUT;
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitOne;
        end
      end
      StHitReq: begin
        load_ck_hit_req = '{load_req: 1'b1, load_addr: op_q.addr};
        wait_cnt_d      = '0;
        state_d         = StHitWait;
      end
      StHitWait: begin
        if (load_hit_resp.load_hit) begin
          state_d = StLdReq;
        end else if (load_hit_resp.load_miss) begin
          retry_cnt_d = retry_cnt_q + RetryOne;
          if (retry_cnt_q == RetryLast) begin
            err_d   = LSU_RETRY;
            state_d = StDone;
          end else begin
            state_d = StHitReq;
          end
        end else if (wait_cnt_q == WaitLast) begin
          err_d   = LSU_TIMEOUT;
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitOne;
        end
      end
      StLdReq: begin
        load_data_req = '{load_req: 1'b1, load_addr: op_q.addr};
        wait_cnt_d    = '0;
        state_d       = StLdWait;
      end
      StLdWait: begin
        if (load_data_resp.load_finished && !load_data_resp.load_miss) begin
          rdata_d = load_data_resp.load_data;
          state_d = StDone;
        end else if (load_data_resp.load_miss) begin
          state_d = StLdReq;
        end else if (wait_cnt_q == WaitLast) begin
          err_d   = LSU_TIMEOUT;
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitOne;
        end
      end
      StDone: begin
        done_valid  = 1'b1;
        done_tag    = op_q.tag[TAG_W-1:0];
        done_rdata  = rdata_q;
        done_err    = err_q;
        retry_cnt_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      err_q       <= LSU_OK;
      rdata_q     <= '0;
      retry_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      retry_cnt_q <= retry_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_falco_lsu_requester.sv
// Directed bench for falco_lsu_requester with a small behavioural memory.
`ifndef SIZE_OF_THE_BUS
`define SIZE_OF_THE_BUS 32
`endif

module tb_falco_lsu_requester;
  import falco_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic        op_is_store = 1'b0;
  logic [31:0] op_addr = '0;
  logic [31:0] op_wdata = '0;
  logic [3:0]  op_tag = '0;
  core_store_req_t       store_req;
  core_load_ck_hit_req_t load_ck_hit_req;
  core_load_data_req_t   load_data_req;
  core_store_resp_t      store_resp;
  core_load_hit_resp_t   load_hit_resp;
  core_load_data_resp_t  load_data_resp;
  logic        done_valid;
  logic [3:0]  done_tag;
  logic [31:0] done_rdata;
  logic [1:0]  done_err;

  // Memory-side response levels, driven by the tests
  logic st_fin = 1'b0, st_miss = 1'b0, lh_hit = 1'b0, lh_miss = 1'b0;
  logic ld_fin = 1'b0, ld_miss = 1'b0;
  logic [31:0] ld_data_q = '0;
  logic [31:0] mem [256];

  int st_cnt = 0, hit_cnt = 0, ld_cnt = 0, multi_cnt = 0;
  logic [31:0] st_addr_seen = '0, st_data_seen = '0;
  int n_cmp = 0, n_fail = 0;

  assign store_resp     = {st_fin, st_miss};
  assign load_hit_resp  = {lh_hit, lh_miss};
  assign load_data_resp = {ld_data_q, ld_fin, ld_miss};

  falco_lsu_requester #(
    .FIFO_DEPTH (4),
    .TAG_W      (4),
    .MAX_RETRY  (3),
    .TIMEOUT    (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_is_store     (op_is_store),
    .op_addr         (op_addr),
    .op_wdata        (op_wdata),
    .op_tag          (op_tag),
    .store_req       (store_req),
    .load_ck_hit_req (load_ck_hit_req),
    .load_data_req   (load_data_req),
    .store_resp      (store_resp),
    .load_hit_resp   (load_hit_resp),
    .load_data_resp  (load_data_resp),
    .done_valid      (done_valid),
    .done_tag        (done_tag),
    .done_rdata      (done_rdata),
    .done_err        (done_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (store_req.store_req) begin
      st_cnt       <= st_cnt + 1;
      st_addr_seen <= store_req.store_addr;
      st_data_seen <= store_req.store_data;
      mem[store_req.store_addr[9:2]] <= store_req.store_data;
    end
    if (load_ck_hit_req.load_req) hit_cnt <= hit_cnt + 1;
    if (load_data_req.load_req) begin
      ld_cnt    <= ld_cnt + 1;
      ld_data_q <= mem[load_data_req.load_addr[9:2]];
    end
    if (32'(store_req.store_req) + 32'(load_ck_hit_req.load_req) + 32'(load_data_req.load_req) > 1)
      multi_cnt <= multi_cnt + 1;
  end

  // Present an op at the current negedge, hold it until accepted, then drop it.
  task automatic push_op(input logic st, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] t);
    int n;
    op_valid = 1'b1; op_is_store = st; op_addr = a; op_wdata = d; op_tag = t;
    n = 0;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL push_accept tag %0d: op_ready stayed %0b, required 1", t, op_ready);
    end
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output logic got);
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 8;
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_op_ready: got %0b req 1", op_ready); end
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL rst_done_valid: got %0b req 0", done_valid); end
    if (done_tag !== 4'h0) begin n_fail++; $display("FAIL rst_done_tag: got %0h req 0", done_tag); end
    if (done_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_done_rdata: got %0h req 0", done_rdata); end
    if (done_err !== 2'd0) begin n_fail++; $display("FAIL rst_done_err: got %0d req 0", done_err); end
    if (store_req !== '0) begin n_fail++; $display("FAIL rst_store_req: got %0h req 0", store_req); end
    if (load_ck_hit_req !== '0) begin n_fail++; $display("FAIL rst_hit_req: got %0h req 0", load_ck_hit_req); end
    if (load_data_req !== '0) begin n_fail++; $display("FAIL rst_data_req: got %0h req 0", load_data_req); end
  endtask

  task automatic test_store;
    int s0, cyc;
    logic got;
    st_fin = 1'b1;
    s0 = st_cnt;
    push_op(1'b1, 32'h100, 32'hDEADBEEF, 4'd2);
    wait_done(40, cyc, got);
    n_cmp += 8;
    if (!got || cyc != 4) begin n_fail++; $display("FAIL st_latency: got %0d (seen %0b) req 4", cyc, got); end
    if (done_tag !== 4'd2) begin n_fail++; $display("FAIL st_tag: got %0d req 2", done_tag); end
    if (done_err !== 2'd0) begin n_fail++; $display("FAIL st_err: got %0d req 0", done_err); end
    if (done_rdata !== 32'h0) begin n_fail++; $display("FAIL st_rdata: got %0h req 0", done_rdata); end
    if (st_cnt - s0 != 1) begin n_fail++; $display("FAIL st_strobes: got %0d req 1", st_cnt - s0); end
    if (st_addr_seen !== 32'h100) begin n_fail++; $display("FAIL st_addr: got %0h req 100", st_addr_seen); end
    if (st_data_seen !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_data: got %0h req deadbeef", st_data_seen); end
    @(negedge clk);
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL st_done_pulse: got %0b req 0", done_valid); end
  endtask

  task automatic test_load;
    int h0, l0, cyc;
    logic got;
    lh_hit = 1'b1; ld_fin = 1'b1;
    h0 = hit_cnt; l0 = ld_cnt;
    push_op(1'b0, 32'h100, 32'h0, 4'd3);
    wait_done(40, cyc, got);
    n_cmp += 6;
    if (!got || cyc != 6) begin n_fail++; $display("FAIL ld_latency: got %0d (seen %0b) req 6", cyc, got); end
    if (done_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_rdata: got %0h req deadbeef", done_rdata); end
    if (done_tag !== 4'd3) begin n_fail++; $display("FAIL ld_tag: got %0d req 3", done_tag); end
    if (done_err !== 2'd0) begin n_fail++; $display("FAIL ld_err: got %0d req 0", done_err); end
    if (hit_cnt - h0 != 1) begin n_fail++; $display("FAIL ld_hit_strobes: got %0d req 1", hit_cnt - h0); end
    if (ld_cnt - l0 != 1) begin n_fail++; $display("FAIL ld_data_strobes: got %0d req 1", ld_cnt - l0); end
  endtask

  task automatic test_misalign;
    int s0, h0, l0, cyc;
    logic got;
    s0 = st_cnt; h0 = hit_cnt; l0 = ld_cnt;
    push_op(1'b0, 32'h203, 32'h0, 4'd5);
    wait_done(40, cyc, got);
    n_cmp += 5;
    if (!got || cyc != 2) begin n_fail++; $display("FAIL mis_latency: got %0d (seen %0b) req 2", cyc, got); end
    if (done_err !== 2'd1) begin n_fail++; $display("FAIL mis_err: got %0d req 1", done_err); end
    if (done_tag !== 4'd5) begin n_fail++; $display("FAIL mis_tag: got %0d req 5", done_tag); end
    if (done_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %0h req 0", done_rdata); end
    if ((st_cnt - s0) + (hit_cnt - h0) + (ld_cnt - l0) != 0) begin
      n_fail++;
      $display("FAIL mis_strobes: got %0d req 0", (st_cnt - s0) + (hit_cnt - h0) + (ld_cnt - l0));
    end
  endtask

  task automatic test_retry;
    int h0, l0, cyc;
    logic got;
    lh_hit = 1'b0; lh_miss = 1'b1;
    h0 = hit_cnt; l0 = ld_cnt;
    push_op(1'b0, 32'h104, 32'h0, 4'd6);
    wait_done(60, cyc, got);
    n_cmp += 5;
    if (!got || cyc != 8) begin n_fail++; $display("FAIL rty_latency: got %0d (seen %0b) req 8", cyc, got); end
    if (done_err !== 2'd2) begin n_fail++; $display("FAIL rty_err: got %0d req 2", done_err); end
    if (done_tag !== 4'd6) begin n_fail++; $display("FAIL rty_tag: got %0d req 6", done_tag); end
    if (hit_cnt - h0 != 3) begin n_fail++; $display("FAIL rty_hit_strobes: got %0d req 3", hit_cnt - h0); end
    if (ld_cnt - l0 != 0) begin n_fail++; $display("FAIL rty_data_strobes: got %0d req 0", ld_cnt - l0); end
    lh_miss = 1'b0;
  endtask

  task automatic test_timeout;
    int s0, cyc;
    logic got;
    st_fin = 1'b0;
    s0 = st_cnt;
    push_op(1'b1, 32'h108, 32'h12345678, 4'd1);
    wait_done(60, cyc, got);
    n_cmp += 4;
    // ST_WAIT is entered 3 cycles after the pop; the error lands TIMEOUT cycles later
    if (!got || cyc != 19) begin n_fail++; $display("FAIL to_latency: got %0d (seen %0b) req 19", cyc, got); end
    if (done_err !== 2'd3) begin n_fail++; $display("FAIL to_err: got %0d req 3", done_err); end
    if (done_tag !== 4'd1) begin n_fail++; $display("FAIL to_tag: got %0d req 1", done_tag); end
    if (st_cnt - s0 != 1) begin n_fail++; $display("FAIL to_strobes: got %0d req 1", st_cnt - s0); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic got;
    st_fin = 1'b0;
    for (int i = 0; i < 5; i++) push_op(1'b1, 32'h140 + 32'(i * 4), 32'(i), 4'(i));
    n_cmp++;
    if (op_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: op_ready got %0b req 0", op_ready); end
    for (int i = 0; i < 5; i++) begin
      wait_done(40, cyc, got);
      n_cmp += 2;
      if (!got || done_tag !== 4'(i)) begin
        n_fail++;
        $display("FAIL b2b_order %0d: tag got %0d (seen %0b) req %0d", i, done_tag, got, i);
      end
      if (done_err !== 2'd3) begin n_fail++; $display("FAIL b2b_err %0d: got %0d req 3", i, done_err); end
    end
  endtask

  task automatic test_reset_midop;
    int s0, h0, l0, n, dones;
    lh_hit = 1'b1; ld_fin = 1'b0; st_fin = 1'b0;
    push_op(1'b0, 32'h100, 32'h0, 4'd7);
    push_op(1'b1, 32'h10C, 32'h1, 4'd8);
    push_op(1'b1, 32'h110, 32'h2, 4'd9);
    n = 0;
    while (!load_data_req.load_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 40) begin n_fail++; $display("FAIL rm_ld_strobe: not seen, req within 40 cycles"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp += 6;
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rm_op_ready: got %0b req 1", op_ready); end
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL rm_done_valid: got %0b req 0", done_valid); end
    if (done_tag !== 4'h0) begin n_fail++; $display("FAIL rm_done_tag: got %0h req 0", done_tag); end
    if (done_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_done_rdata: got %0h req 0", done_rdata); end
    if (done_err !== 2'd0) begin n_fail++; $display("FAIL rm_done_err: got %0d req 0", done_err); end
    if ((store_req !== '0) || (load_ck_hit_req !== '0) || (load_data_req !== '0)) begin
      n_fail++;
      $display("FAIL rm_strobes: got %0b%0b%0b req 000", store_req.store_req,
               load_ck_hit_req.load_req, load_data_req.load_req);
    end
    s0 = st_cnt; h0 = hit_cnt; l0 = ld_cnt;
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_valid) dones++;
    end
    n_cmp += 2;
    if (dones != 0) begin n_fail++; $display("FAIL rm_no_done: got %0d completions req 0", dones); end
    if ((st_cnt - s0) + (hit_cnt - h0) + (ld_cnt - l0) != 0) begin
      n_fail++;
      $display("FAIL rm_flushed: got %0d strobes req 0", (st_cnt - s0) + (hit_cnt - h0) + (ld_cnt - l0));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_retry();
    test_timeout();
    test_back_to_back();
    test_reset_midop();
    n_cmp++;
    if (multi_cnt != 0) begin n_fail++; $display("FAIL one_strobe: got %0d overlap cycles req 0", multi_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
